// File: rtl/gol_pkg.sv
// Shared Game-of-Life grid definitions used by the cell array and its seed/pattern loaders.
// Optional feature macro used by the pattern loader: GRID_LOADER_CHECKSUM_EN.
package gol_pkg;

  localparam int GRIDWIDTH  = 32;
  localparam int GRIDHEIGHT = 24;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int BYTES_PER_ROW = GRIDWIDTH / 8;
  localparam int ROW_W  = (GRIDHEIGHT > 1) ? $clog2(GRIDHEIGHT) : 1;
  localparam int BIDX_W = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;

  // A single cell's state in the array.
  typedef enum logic {
    ENT_DEAD  = 1'b0,
    ENT_ALIVE = 1'b1
  } entity_e;

  // Neighbourhood condition that decides a cell's next state.
  typedef enum logic [1:0] {
    COND_LONELY,
    COND_STABLE,
    COND_BIRTH,
    COND_CROWDED
  } condition_e;

  // Which source owns the default state of the grid.
  typedef enum logic [1:0] {
    COAL_NONE,
    COAL_RANDOM_SEED,
    COAL_UART_PATTERN
  } coalition_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: 2-flop synchronizer, mid-bit sampling with a down-counter timer.
module uart_rx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(DIV - 1);

  // RX_BREAK holds off after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Synchronizer and edge-history flops; all reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver state, bit timer, bit index, shift register and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state: half a bit to the start-bit centre, then one full bit per sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = HALF_LD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_LD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_LD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_BREAK: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/grid_pattern_loader.sv
// Loads a UART-delivered seed pattern into the cell grid one row per write pulse.
// Define GRID_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
//
// state        | meaning
// LD_WAIT_SYNC | discard bytes until SYNC_BYTE
// LD_LOAD      | fill row buffer, write each completed row
// LD_LAST      | (no checksum) pulse load_done after the last row write
// LD_CHECK     | (checksum) compare trailing byte with running XOR
module grid_pattern_loader
  import gol_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 wr_en,
  output logic [ROW_W-1:0]     wr_row,
  output logic [GRIDWIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 load_done,
  output logic                 frame_err
);

  localparam int DIV = CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    LD_WAIT_SYNC,
    LD_LOAD,
`ifdef GRID_LOADER_CHECKSUM_EN
    LD_CHECK
`else
    LD_LAST
`endif
  } ld_state_e;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  ld_state_e            state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [GRIDWIDTH-1:0] rowbuf_q, rowbuf_d;
  logic                 wr_en_q, wr_en_d;
  logic [ROW_W-1:0]     wr_row_q, wr_row_d;
  logic [GRIDWIDTH-1:0] wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 load_done_q, load_done_d;
  logic                 frame_err_q, frame_err_d;
  logic [GRIDWIDTH-1:0] filled;
  logic                 row_full, last_row;
`ifdef GRID_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  // Loader state, counters, row buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LD_WAIT_SYNC;
      row_q       <= '0;
      bidx_q      <= '0;
      rowbuf_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef GRID_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      bidx_q      <= bidx_d;
      rowbuf_q    <= rowbuf_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
`ifdef GRID_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state and output pulses; all outputs are registered one cycle after the byte event.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    bidx_d      = bidx_q;
    rowbuf_d    = rowbuf_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    load_done_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef GRID_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    filled = rowbuf_q;
    filled[int'(bidx_q) * 8 +: 8] = byte_data;
    row_full = (bidx_q == BIDX_W'(BYTES_PER_ROW - 1));
    last_row = (row_q == ROW_W'(GRIDHEIGHT - 1));

    case (state_q)
      LD_WAIT_SYNC: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = LD_LOAD;
          row_d   = '0;
          bidx_d  = '0;
          busy_d  = 1'b1;
`ifdef GRID_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LD_LOAD: begin
        if (byte_err) begin
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = LD_WAIT_SYNC;
        end else if (byte_valid) begin
          rowbuf_d = filled;
`ifdef GRID_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ byte_data;
`endif
          if (row_full) begin
            bidx_d    = '0;
            wr_en_d   = 1'b1;
            wr_row_d  = row_q;
            wr_data_d = filled;
            if (last_row) begin
`ifdef GRID_LOADER_CHECKSUM_EN
              state_d = LD_CHECK;
`else
              state_d = LD_LAST;
`endif
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
`ifdef GRID_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (byte_err) begin
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = LD_WAIT_SYNC;
        end else if (byte_valid) begin
          if (byte_data == csum_q) load_done_d = 1'b1;
          else                     frame_err_d = 1'b1;
          busy_d  = 1'b0;
          state_d = LD_WAIT_SYNC;
        end
      end
`else
      LD_LAST: begin
        load_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = LD_WAIT_SYNC;
      end
`endif
      default: state_d = LD_WAIT_SYNC;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_row    = wr_row_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_grid_pattern_loader.sv
// Directed bench for grid_pattern_loader at DIV=10; honours GRID_LOADER_CHECKSUM_EN.
module tb_grid_pattern_loader;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [31:0] wr_data;
  logic        busy, load_done, frame_err;

  grid_pattern_loader #(.CLK_HZ(1_000_000), .BAUD(100_000)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .busy     (busy),
    .load_done(load_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor: logs writes and counts pulses, sampled on the falling edge.
  int          cyc = 0;
  logic [4:0]  wr_row_log[$];
  logic [31:0] wr_data_log[$];
  int          wr_cyc_log[$];
  logic        wr_busy_last = 1'b0;
  int          ld_cnt = 0, ld_cyc = 0, fe_cnt = 0, overlap = 0, bv_cnt = 0, be_cnt = 0;
  logic        ld_busy = 1'b1, fe_busy = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (wr_en) begin
        wr_row_log.push_back(wr_row);
        wr_data_log.push_back(wr_data);
        wr_cyc_log.push_back(cyc);
        wr_busy_last = busy;
      end
      if (load_done) begin
        ld_cnt++;
        ld_cyc  = cyc;
        ld_busy = busy;
      end
      if (frame_err) begin
        fe_cnt++;
        fe_busy = busy;
      end
      if (wr_en && load_done) overlap++;
      if (u_dut.byte_valid) bv_cnt++;
      if (u_dut.byte_err) be_cnt++;
    end
  end

  task automatic bit_period(input logic v);
    uart_rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop_ok);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] frame_q[$];

  task automatic build_frame();
    logic [7:0] x;
    x = 8'h00;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    for (int r = 0; r < 24; r++) begin
      frame_q.push_back(8'(r));
      frame_q.push_back(8'h00);
      frame_q.push_back(8'hFF);
      frame_q.push_back(8'h5A);
      x = x ^ 8'(r) ^ 8'h00 ^ 8'hFF ^ 8'h5A;
    end
`ifdef GRID_LOADER_CHECKSUM_EN
    frame_q.push_back(x);
`endif
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(frame_q[i], 1'b1);
  endtask

  task automatic check_full_frame(input string tag, input int wb, input int lb, input int fb);
    logic [31:0] exp_data;
    chk({tag, "_nwr"}, 64'(wr_row_log.size() - wb), 64'd24);
    for (int r = 0; r < 24; r++) begin
      if (wb + r < wr_row_log.size()) begin
        exp_data = {8'h5A, 8'hFF, 8'h00, 8'(r)};
        chk({tag, "_row"}, 64'(wr_row_log[wb + r]), 64'(r));
        chk({tag, "_data"}, 64'(wr_data_log[wb + r]), 64'(exp_data));
      end
    end
    chk({tag, "_ld_cnt"}, 64'(ld_cnt - lb), 64'd1);
    chk({tag, "_fe_cnt"}, 64'(fe_cnt - fb), 64'd0);
`ifndef GRID_LOADER_CHECKSUM_EN
    if (wr_cyc_log.size() > 0)
      chk({tag, "_ld_delay"}, 64'(ld_cyc - wr_cyc_log[wr_cyc_log.size() - 1]), 64'd1);
`endif
    chk({tag, "_busy_at_last_wr"}, 64'(wr_busy_last), 64'd1);
    chk({tag, "_busy_at_ld"}, 64'(ld_busy), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_row"}, 64'(wr_row), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb, lb, fb, bv0, be0;

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Full frame
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    build_frame();
    send_byte(frame_q[0], 1'b1);
    chk("s1_busy_after_sync", 64'(busy), 64'd1);
    send_range(1, frame_q.size() - 1);
    repeat (5) @(negedge clk);
    check_full_frame("s1", wb, lb, fb);

    // Noise before sync
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    chk("s2_busy_noise", 64'(busy), 64'd0);
    chk("s2_nwr_noise", 64'(wr_row_log.size() - wb), 64'd0);
    build_frame();
    send_range(0, 3);
    chk("s2_nwr_pre4", 64'(wr_row_log.size() - wb), 64'd0);
    send_range(4, 4);
    chk("s2_nwr_at4", 64'(wr_row_log.size() - wb), 64'd1);
    send_range(5, frame_q.size() - 1);
    repeat (5) @(negedge clk);
    check_full_frame("s2", wb, lb, fb);

    // Framing error on the 11th data byte
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    build_frame();
    send_range(0, 10);
    send_byte(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    chk("s3_nwr", 64'(wr_row_log.size() - wb), 64'd2);
    if (wr_row_log.size() >= wb + 2) begin
      chk("s3_row0", 64'(wr_row_log[wb]), 64'd0);
      chk("s3_row1", 64'(wr_row_log[wb + 1]), 64'd1);
    end
    chk("s3_fe_cnt", 64'(fe_cnt - fb), 64'd1);
    chk("s3_busy_at_fe", 64'(fe_busy), 64'd0);
    chk("s3_busy", 64'(busy), 64'd0);
    chk("s3_ld_cnt", 64'(ld_cnt - lb), 64'd0);
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    send_range(0, frame_q.size() - 1);
    repeat (5) @(negedge clk);
    check_full_frame("s3_reload", wb, lb, fb);

    // Start-bit glitch while waiting for sync
    bv0 = bv_cnt; be0 = be_cnt;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("s4_no_byte", 64'(bv_cnt - bv0), 64'd0);
    chk("s4_no_err", 64'(be_cnt - be0), 64'd0);
    chk("s4_busy", 64'(busy), 64'd0);

    // Reset mid-frame (reuses the glitch recovery: sync must be received)
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    build_frame();
    send_range(0, 0);
    chk("s4_recv_after_glitch", 64'(busy), 64'd1);
    send_range(1, 24);
    chk("s5_nwr_pre_rst", 64'(wr_row_log.size() - wb), 64'd6);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("s5_in_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("s5_post_rst");
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    send_range(25, 32);
    repeat (5) @(negedge clk);
    chk("s5_ignored_nwr", 64'(wr_row_log.size() - wb), 64'd0);
    chk("s5_ignored_ld", 64'(ld_cnt - lb), 64'd0);
    chk("s5_ignored_fe", 64'(fe_cnt - fb), 64'd0);
    chk("s5_ignored_busy", 64'(busy), 64'd0);
    send_range(0, 4);
    chk("s5_restart_nwr", 64'(wr_row_log.size() - wb), 64'd1);
    if (wr_row_log.size() > wb) begin
      chk("s5_restart_row", 64'(wr_row_log[wb]), 64'd0);
      chk("s5_restart_data", 64'(wr_data_log[wb]), 64'h5AFF0000);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

`ifdef GRID_LOADER_CHECKSUM_EN
    // Checksum: good frame then corrupted checksum
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    build_frame();
    send_range(0, frame_q.size() - 1);
    repeat (5) @(negedge clk);
    check_full_frame("s6_good", wb, lb, fb);
    wb = wr_row_log.size(); lb = ld_cnt; fb = fe_cnt;
    build_frame();
    frame_q[frame_q.size() - 1] = frame_q[frame_q.size() - 1] ^ 8'h01;
    send_range(0, frame_q.size() - 1);
    repeat (5) @(negedge clk);
    chk("s6_bad_nwr", 64'(wr_row_log.size() - wb), 64'd24);
    chk("s6_bad_ld", 64'(ld_cnt - lb), 64'd0);
    chk("s6_bad_fe", 64'(fe_cnt - fb), 64'd1);
    chk("s6_bad_busy", 64'(busy), 64'd0);
`endif

    chk("no_wr_ld_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
